// File: rtl/maxnet_feedback_stage_if.sv
// Handshake bundle between the controller/PU side and the MAXNET feedback stage.
// Lane k of every group (init, pu_out, feed) is lane index k-1 in winner.
interface maxnet_feedback_stage_if #(
  parameter int IN_W   = 5,
  parameter int SUM_W  = 12,
  parameter int ITER_W = 4
) ();
  logic              start;
  logic [IN_W-1:0]   init1, init2, init3, init4;
  logic [SUM_W-1:0]  pu_out1, pu_out2, pu_out3, pu_out4;
  logic              pu_valid;
  logic [IN_W-1:0]   feed1, feed2, feed3, feed4;
  logic              feed_valid;
  logic              done;
  logic [1:0]        winner;
  logic              no_winner;
  logic [ITER_W-1:0] iter_count;

  modport master (
    output start, init1, init2, init3, init4,
    output pu_out1, pu_out2, pu_out3, pu_out4, pu_valid,
    input  feed1, feed2, feed3, feed4, feed_valid,
    input  done, winner, no_winner, iter_count
  );

  modport slave (
    input  start, init1, init2, init3, init4,
    input  pu_out1, pu_out2, pu_out3, pu_out4, pu_valid,
    output feed1, feed2, feed3, feed4, feed_valid,
    output done, winner, no_winner, iter_count
  );
endinterface

// File: rtl/maxnet_feedback_stage.sv
// MAXNET feedback stage: rectifies and saturates the four PU sums and feeds them back
// to the PU until one lane survives, every lane dies, or the iteration limit is hit.
module maxnet_feedback_stage #(
  parameter int IN_W     = 5,
  parameter int SUM_W    = 12,
  parameter int SHIFT    = 0,
  parameter int MAX_ITER = 15,
  parameter int ITER_W   = 4
) (
  input logic clk,
  input logic rst,
  maxnet_feedback_stage_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, EVAL, DONE} state_t;

  localparam logic signed [SUM_W-1:0] ACT_MAX      = SUM_W'((1 << IN_W) - 1);
  localparam logic [ITER_W-1:0]       MAX_ITER_VAL = ITER_W'(MAX_ITER);

  state_t            state_reg;
  logic [IN_W-1:0]   feed_reg [4];
  logic [IN_W-1:0]   act_reg  [4];
  logic              feed_valid_reg;
  logic              done_reg;
  logic [1:0]        winner_reg;
  logic              no_winner_reg;
  logic [ITER_W-1:0] iter_count_reg;

  logic [SUM_W-1:0]  sum_in   [4];
  logic [IN_W-1:0]   init_in  [4];
  logic [IN_W-1:0]   act_next [4];
  logic [3:0]        alive;
  logic [2:0]        n_alive;
  logic [1:0]        win_idx;
  logic [ITER_W-1:0] it_new;

  function automatic logic [IN_W-1:0] act_f(input logic [SUM_W-1:0] s);
    logic signed [SUM_W-1:0] t;
    t = $signed(s) >>> SHIFT;
    if (t < 0)
      return '0;
    else if (t > ACT_MAX)
      return '1;
    else
      return t[IN_W-1:0];
  endfunction

  assign sum_in[0]  = bus.pu_out1;
  assign sum_in[1]  = bus.pu_out2;
  assign sum_in[2]  = bus.pu_out3;
  assign sum_in[3]  = bus.pu_out4;
  assign init_in[0] = bus.init1;
  assign init_in[1] = bus.init2;
  assign init_in[2] = bus.init3;
  assign init_in[3] = bus.init4;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign act_next[gi] = act_f(sum_in[gi]);
      assign alive[gi]    = (act_reg[gi] != '0);
    end
  endgenerate

  // win_idx is only meaningful when exactly one lane is alive.
  always_comb begin
    n_alive = '0;
    win_idx = '0;
    for (int i = 0; i < 4; i++) begin
      n_alive = n_alive + 3'(alive[i]);
      if (alive[i])
        win_idx = 2'(i);
    end
  end

  assign it_new = iter_count_reg + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      feed_valid_reg <= 1'b0;
      done_reg       <= 1'b0;
      winner_reg     <= '0;
      no_winner_reg  <= 1'b0;
      iter_count_reg <= '0;
      for (int i = 0; i < 4; i++) begin
        feed_reg[i] <= '0;
        act_reg[i]  <= '0;
      end
    end else begin
      feed_valid_reg <= 1'b0;
      case (state_reg)
        IDLE, DONE: begin
          if (bus.start) begin
            for (int i = 0; i < 4; i++)
              feed_reg[i] <= init_in[i];
            feed_valid_reg <= 1'b1;
            iter_count_reg <= '0;
            done_reg       <= 1'b0;
            state_reg      <= WAIT;
          end
        end
        WAIT: begin
          // A pu_valid coinciding with the feed pulse belongs to the previous feed.
          if (bus.pu_valid && !feed_valid_reg) begin
            for (int i = 0; i < 4; i++)
              act_reg[i] <= act_next[i];
            state_reg <= EVAL;
          end
        end
        EVAL: begin
          iter_count_reg <= it_new;
          if (n_alive == 3'd1) begin
            winner_reg    <= win_idx;
            no_winner_reg <= 1'b0;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else if (n_alive == 3'd0) begin
            winner_reg    <= '0;
            no_winner_reg <= 1'b1;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else if (it_new == MAX_ITER_VAL) begin
            no_winner_reg <= 1'b1;
            done_reg      <= 1'b1;
            state_reg     <= DONE;
          end else begin
            for (int i = 0; i < 4; i++)
              feed_reg[i] <= act_reg[i];
            feed_valid_reg <= 1'b1;
            state_reg      <= WAIT;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.feed1      = feed_reg[0];
  assign bus.feed2      = feed_reg[1];
  assign bus.feed3      = feed_reg[2];
  assign bus.feed4      = feed_reg[3];
  assign bus.feed_valid = feed_valid_reg;
  assign bus.done       = done_reg;
  assign bus.winner     = winner_reg;
  assign bus.no_winner  = no_winner_reg;
  assign bus.iter_count = iter_count_reg;
endmodule

// File: tb/tb_maxnet_feedback_stage.sv
// Bench for maxnet_feedback_stage: directed scenarios plus randomized runs, with the
// bench itself acting as the PU and predicting every outcome from the lane rules.
module tb_maxnet_feedback_stage;
  localparam int SHIFT    = 0;
  localparam int MAX_ITER = 15;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   fv_count = 0;

  always #5 clk = ~clk;

  maxnet_feedback_stage_if #(.IN_W(5), .SUM_W(12), .ITER_W(4)) bus ();

  maxnet_feedback_stage #(.IN_W(5), .SUM_W(12), .SHIFT(SHIFT), .MAX_ITER(MAX_ITER), .ITER_W(4)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always @(posedge clk) if (bus.feed_valid === 1'b1) fv_count <= fv_count + 1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int feed_of(input int i);
    case (i)
      0: return int'(bus.feed1);
      1: return int'(bus.feed2);
      2: return int'(bus.feed3);
      default: return int'(bus.feed4);
    endcase
  endfunction

  // Reference rectifier: arithmetic shift, clamp to [0, 31].
  function automatic int act_m(input int s);
    int t;
    t = s >>> SHIFT;
    if (t < 0) return 0;
    if (t > 31) return 31;
    return t;
  endfunction

  task automatic set_pu(input int s[4], input logic v);
    bus.pu_out1  = 12'(s[0]);
    bus.pu_out2  = 12'(s[1]);
    bus.pu_out3  = 12'(s[2]);
    bus.pu_out4  = 12'(s[3]);
    bus.pu_valid = v;
  endtask

  // PU behaviour per scenario: 0 random, 1 saturation, 2 late winner, 3 all die, 4 tie forever.
  task automatic gen_sums(input int mode, input int e, output int s[4]);
    for (int i = 0; i < 4; i++) begin
      case (mode)
        1: s[i] = -5;
        2: s[i] = -3;
        3: s[i] = -int'($urandom_range(1, 2048));
        4: s[i] = (i % 2 == 0) ? 9 : 0;
        default: begin
          case ($urandom_range(0, 3))
            0: s[i] = -int'($urandom_range(1, 2048));
            1: s[i] = 0;
            2: s[i] = int'($urandom_range(1, 60));
            default: s[i] = int'($urandom_range(1, 2047));
          endcase
        end
      endcase
    end
    if (mode == 1 && e == 0) s = '{-1, 40, 17, 0};
    if (mode == 2 && e == 0) s = '{5, 9, 7, 2};
    if (mode == 2 && e == 1) s = '{-3, 0, 7, -100};
  endtask

  task automatic check_feeds(input string tag, input int exp_f[4]);
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s_lane%0d", tag, i + 1), 32'(feed_of(i)), 32'(exp_f[i]));
  endtask

  task automatic run_case(input int mode, input int init_v[4], input int exp_iter,
                          input int exp_nw, input int exp_win, input int exp_pulses);
    int  feed_m[4];
    int  sums[4];
    int  act[4];
    int  garbage[4];
    int  e, n, w, base, waits;
    bit  fin, stale;
    base = fv_count;
    bus.init1 = 5'(init_v[0]);
    bus.init2 = 5'(init_v[1]);
    bus.init3 = 5'(init_v[2]);
    bus.init4 = 5'(init_v[3]);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    chk("start_feed_valid", 32'(bus.feed_valid), 1);
    chk("start_done_low", 32'(bus.done), 0);
    chk("start_iter_zero", 32'(bus.iter_count), 0);
    feed_m = init_v;
    check_feeds("start_feed", feed_m);
    e = 0;
    fin = 1'b0;
    w = 0;
    while (!fin && e < 20) begin
      stale = ($urandom_range(0, 3) == 0);
      if (stale) begin
        garbage = '{31, 31, 31, 31};
        set_pu(garbage, 1'b1);
      end
      tick();
      bus.pu_valid = 1'b0;
      chk("pulse_single", 32'(bus.feed_valid), 0);
      waits = int'($urandom_range(0, 2)) + (stale ? 1 : 0);
      for (int k = 0; k < waits; k++) begin
        bus.start = 1'($urandom_range(0, 1));
        tick();
        chk("wait_no_feed", 32'(bus.feed_valid), 0);
        chk("wait_no_done", 32'(bus.done), 0);
      end
      gen_sums(mode, e, sums);
      set_pu(sums, 1'b1);
      bus.start = 1'($urandom_range(0, 1));
      tick();
      bus.pu_valid = 1'b0;
      bus.start = 1'b0;
      chk("eval_no_feed", 32'(bus.feed_valid), 0);
      tick();
      n = 0;
      for (int i = 0; i < 4; i++) begin
        act[i] = act_m(sums[i]);
        if (act[i] != 0) begin
          n++;
          w = i;
        end
      end
      e++;
      if (n <= 1 || e == MAX_ITER) begin
        fin = 1'b1;
        chk("end_done", 32'(bus.done), 1);
        chk("end_feed_valid", 32'(bus.feed_valid), 0);
        chk("end_iter", 32'(bus.iter_count), 32'(e));
        chk("end_no_winner", 32'(bus.no_winner), (n == 1) ? 0 : 1);
        if (n == 1) chk("end_winner", 32'(bus.winner), 32'(w));
        if (n == 0) chk("end_winner_zero", 32'(bus.winner), 0);
      end else begin
        chk("cont_feed_valid", 32'(bus.feed_valid), 1);
        chk("cont_done_low", 32'(bus.done), 0);
        feed_m = act;
        check_feeds("cont_feed", feed_m);
        if (mode == 1 && e == 1) check_feeds("sat_feed", '{0, 31, 17, 0});
      end
    end
    chk("run_terminated", 32'(fin), 1);
    repeat (3) tick();
    chk("hold_done", 32'(bus.done), 1);
    check_feeds("hold_feed", feed_m);
    if (exp_iter >= 0) chk("exp_iter", 32'(bus.iter_count), 32'(exp_iter));
    if (exp_nw >= 0) chk("exp_no_winner", 32'(bus.no_winner), 32'(exp_nw));
    if (exp_win >= 0) chk("exp_winner", 32'(bus.winner), 32'(exp_win));
    if (exp_pulses >= 0) chk("feed_pulses", 32'(fv_count - base), 32'(exp_pulses));
    $display("run mode=%0d evals=%0d done=%0b winner=%0d no_winner=%0b iter=%0d",
             mode, e, bus.done, bus.winner, bus.no_winner, bus.iter_count);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_feed_valid"}, 32'(bus.feed_valid), 0);
    chk({tag, "_done"}, 32'(bus.done), 0);
    chk({tag, "_winner"}, 32'(bus.winner), 0);
    chk({tag, "_no_winner"}, 32'(bus.no_winner), 0);
    chk({tag, "_iter"}, 32'(bus.iter_count), 0);
    check_feeds({tag, "_feed"}, '{0, 0, 0, 0});
  endtask

  initial begin
    int rnd_init[4];
    int s[4];
    rst = 1'b1;
    bus.start = 1'b1;
    bus.init1 = 5'd7;
    bus.init2 = 5'd8;
    bus.init3 = 5'd9;
    bus.init4 = 5'd10;
    s = '{31, 31, 31, 31};
    set_pu(s, 1'b1);
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    bus.start = 1'b0;
    bus.pu_valid = 1'b0;
    tick();
    chk("post_reset_feed_valid", 32'(bus.feed_valid), 0);
    chk("post_reset_done", 32'(bus.done), 0);
    $display("reset scenario complete");

    run_case(1, '{1, 2, 3, 4}, 2, 1, 0, 2);
    run_case(2, '{10, 20, 5, 3}, 2, 0, 2, 2);
    run_case(3, '{31, 0, 12, 6}, 1, 1, 0, 1);
    run_case(4, '{4, 4, 4, 4}, 15, 1, -1, 15);

    // Abort in WAIT, then show a late pu_valid in IDLE does nothing.
    bus.init1 = 5'd3;
    bus.init2 = 5'd3;
    bus.init3 = 5'd3;
    bus.init4 = 5'd3;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_all_zero("abort");
    s = '{0, 0, 6, 0};
    set_pu(s, 1'b1);
    tick();
    bus.pu_valid = 1'b0;
    repeat (3) tick();
    chk("abort_no_done", 32'(bus.done), 0);
    chk("abort_no_feed", 32'(bus.feed_valid), 0);
    $display("abort scenario complete");

    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < 4; i++) rnd_init[i] = int'($urandom_range(0, 31));
      run_case(0, rnd_init, -1, -1, -1, -1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
